// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter (optional 4-period averaging: PERIOD_METER_AVG4_EN).
package period_meter_pkg;

  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 100_000_000;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

endpackage

// File: rtl/period_meter_if.sv
// Measurement bus of the period meter: control/signal in, result and status out.
interface period_meter_if
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  // num_valid is a one-cycle strobe with no back-pressure: num is updated in
  // the same cycle num_valid is high and then holds until the next strobe.
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] num;
  logic             num_valid;
  logic             timeout;
  logic             locked;
  state_t           state;

  modport master (
    output en, sig_in,
    input  num, num_valid, timeout, locked, state
  );

  modport slave (
    input  en, sig_in,
    output num, num_valid, timeout, locked, state
  );

endinterface

// File: rtl/period_meter_sync_rise.sv
// Synchronizer for the asynchronous measured signal plus a history flop for
// single-cycle rising-edge detection.
module sync_rise
  import period_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  // sh[0..SYNC_STAGES-1] synchronize, sh[SYNC_STAGES] is the history flop
  logic [SYNC_STAGES:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
    end else begin
      sh <= {sh[SYNC_STAGES-1:0], d};
    end
  end

  assign rise = sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];

endmodule

// File: rtl/period_meter.sv
// Measures the rising-edge period of a slow signal in clk cycles, with timeout.
// Defining PERIOD_METER_AVG4_EN reports the truncated mean of every 4 periods instead.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF)
)(
  input logic          clk,
  input logic          rst_n,
  period_meter_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] num;
  logic             num_valid;
  logic             timeout;
  logic             locked;
  logic             rise;

  sync_rise u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.sig_in),
    .rise (rise)
  );

`ifdef PERIOD_METER_AVG4_EN
  // Four periods each bounded by TIMEOUT fit in CNT_W+2 bits
  logic [CNT_W+1:0] acc;
  logic [CNT_W+1:0] sum;
  logic [1:0]       pcnt;

  assign sum = acc + {2'b00, cnt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      num       <= '0;
      num_valid <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
`ifdef PERIOD_METER_AVG4_EN
      acc       <= '0;
      pcnt      <= '0;
`endif
    end else begin
      num_valid <= 1'b0;
      if (!bus.en) begin
        state  <= IDLE;
        cnt    <= '0;
        locked <= 1'b0;
`ifdef PERIOD_METER_AVG4_EN
        acc    <= '0;
        pcnt   <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
`ifdef PERIOD_METER_AVG4_EN
            acc  <= '0;
            pcnt <= '0;
`endif
            // First edge only opens the measurement window
            if (rise) begin
              state <= MEAS;
              cnt   <= CNT_W'(1);
            end
          end
          MEAS: begin
            // An edge landing on cnt==TIMEOUT still counts as a valid period
            if (rise) begin
              cnt     <= CNT_W'(1);
              timeout <= 1'b0;
`ifdef PERIOD_METER_AVG4_EN
              if (pcnt == 2'd3) begin
                num       <= sum[CNT_W+1:2];
                num_valid <= 1'b1;
                locked    <= 1'b1;
                acc       <= '0;
                pcnt      <= '0;
              end else begin
                acc  <= sum;
                pcnt <= pcnt + 2'd1;
              end
`else
              num       <= cnt;
              num_valid <= 1'b1;
              locked    <= 1'b1;
`endif
            end else if (cnt == TIMEOUT) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              state   <= IDLE;
              cnt     <= '0;
`ifdef PERIOD_METER_AVG4_EN
              acc     <= '0;
              pcnt    <= '0;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.num       = num;
  assign bus.num_valid = num_valid;
  assign bus.timeout   = timeout;
  assign bus.locked    = locked;
  assign bus.state     = state;

endmodule
